axis_actuator_driver: RTL and testbench

AXIS_ACTUATOR_DRIVER -- requirements
Module: axis_actuator_driver

---
 rtl/axis_actuator_driver_pkg.sv | 19 +
 rtl/axis_actuator_driver_slew_limiter.sv | 30 +++
 rtl/axis_actuator_driver.sv | 144 ++++++++++++++
 tb/tb_axis_actuator_driver.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/axis_actuator_driver_pkg.sv
// Shared definitions for the actuator driver: FSM state codes and DAC word helpers.
package axis_actuator_driver_pkg;

    // State codes are visible on the state output, so the encoding is fixed.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_RAIL  = 2'd2,
        ST_HOLD  = 2'd3
    } drv_state_t;

    // Two's complement to offset binary: flip the sign bit of a width-bit word.
    // The value arrives sign-extended to 32 bits; the caller truncates the result.
    function automatic logic [31:0] to_offset_binary(input logic [31:0] value,
                                                     input int unsigned width);
        return value ^ (32'd1 << (width - 1));
    endfunction

endpackage

// File: rtl/axis_actuator_driver_slew_limiter.sv
// Combinational slew limiter: moves cur toward goal by at most max_step (0 = unlimited).
module axis_actuator_driver_slew_limiter #(
    parameter int DAC_WIDTH = 14
) (
    input  logic signed [DAC_WIDTH-1:0] cur,
    input  logic signed [DAC_WIDTH-1:0] goal,
    input  logic        [DAC_WIDTH-2:0] max_step,
    output logic signed [DAC_WIDTH-1:0] next_cur
);

    logic signed [DAC_WIDTH:0] delta;
    logic        [DAC_WIDTH:0] mag;
    logic signed [DAC_WIDTH:0] step_ext;
    logic signed [DAC_WIDTH:0] moved;

    // One extra bit keeps goal - cur exact; the stepped value always lies between
    // cur and goal, so dropping the extra bit afterwards cannot wrap.
    always_comb begin
        delta    = {goal[DAC_WIDTH-1], goal} - {cur[DAC_WIDTH-1], cur};
        mag      = delta[DAC_WIDTH] ? (~delta + {{DAC_WIDTH{1'b0}}, 1'b1}) : delta;
        step_ext = {2'b00, max_step};
        moved    = delta[DAC_WIDTH] ? ({cur[DAC_WIDTH-1], cur} - step_ext)
                                    : ({cur[DAC_WIDTH-1], cur} + step_ext);
        next_cur = goal;
        if ((max_step != '0) && (mag > {2'b00, max_step})) begin
            next_cur = moved[DAC_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/axis_actuator_driver.sv
// AXI-Stream action to DAC driver: scale, offset+saturate, slew limit, rail/hold FSM.
module axis_actuator_driver
    import axis_actuator_driver_pkg::*;
#(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int DAC_WIDTH        = 14,
    parameter int RAIL_COUNT       = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [AXIS_TDATA_WIDTH-1:0] axis_ACTION_tdata,
    input  logic                        axis_ACTION_tvalid,
    output logic                        axis_ACTION_tready,
    input  logic                        en,
    input  logic                        hold,
    input  logic [DAC_WIDTH-1:0]        OFFSET,
    input  logic [DAC_WIDTH-2:0]        MAX_STEP,
    output logic [DAC_WIDTH-1:0]        dac_data,
    output logic                        dac_valid,
    output logic                        rail_flag,
    output logic [1:0]                  state
);

    localparam int CNT_W = $clog2(RAIL_COUNT + 1);

    drv_state_t                  state_reg;
    logic                        s1_valid_reg;
    logic signed [DAC_WIDTH-1:0] s1_sum_reg;
    logic                        s1_sat_reg;
    logic signed [DAC_WIDTH-1:0] cur_reg;
    logic        [DAC_WIDTH-1:0] dac_data_reg;
    logic                        dac_valid_reg;
    logic        [CNT_W-1:0]     rail_cnt_reg;

    logic signed [DAC_WIDTH-1:0] target;
    logic signed [DAC_WIDTH:0]   sum_full;
    logic                        sat_hi;
    logic                        sat_lo;
    logic signed [DAC_WIDTH-1:0] sum_sat;
    logic                        active;
    logic                        accept;
    logic                        s2_fire;
    logic signed [DAC_WIDTH-1:0] cur_next;
    logic        [CNT_W-1:0]     rail_cnt_next;

    // The arithmetic right shift followed by truncation is exactly the top DAC_WIDTH bits.
    assign target             = axis_ACTION_tdata[AXIS_TDATA_WIDTH-1 -: DAC_WIDTH];
    assign active             = (state_reg == ST_TRACK) || (state_reg == ST_RAIL);
    assign axis_ACTION_tready = (state_reg != ST_IDLE);
    assign accept             = axis_ACTION_tvalid && axis_ACTION_tready;
    // A stage-1 sample only reaches the output while tracking; in IDLE/HOLD it is dropped.
    assign s2_fire            = s1_valid_reg && active;

    // Offset add with saturation to the signed DAC range; overflow shows up as a
    // mismatch between the extra sign bit and the DAC sign bit.
    always_comb begin
        sum_full = {target[DAC_WIDTH-1], target} + {OFFSET[DAC_WIDTH-1], OFFSET};
        sat_hi   = !sum_full[DAC_WIDTH] &&  sum_full[DAC_WIDTH-1];
        sat_lo   =  sum_full[DAC_WIDTH] && !sum_full[DAC_WIDTH-1];
        sum_sat  = sum_full[DAC_WIDTH-1:0];
        if (sat_hi) begin
            sum_sat = {1'b0, {(DAC_WIDTH-1){1'b1}}};
        end else if (sat_lo) begin
            sum_sat = {1'b1, {(DAC_WIDTH-1){1'b0}}};
        end
    end

    // Consecutive-saturation counter, pinned at RAIL_COUNT.
    always_comb begin
        rail_cnt_next = '0;
        if (s1_sat_reg) begin
            rail_cnt_next = (rail_cnt_reg == CNT_W'(RAIL_COUNT)) ? rail_cnt_reg
                                                                 : rail_cnt_reg + CNT_W'(1);
        end
    end

    axis_actuator_driver_slew_limiter #(
        .DAC_WIDTH(DAC_WIDTH)
    ) u_slew (
        .cur      (cur_reg),
        .goal     (s1_sum_reg),
        .max_step (MAX_STEP),
        .next_cur (cur_next)
    );

    // Two-stage pipeline and mode FSM; en=0 beats hold, which beats rail tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            s1_valid_reg  <= 1'b0;
            s1_sum_reg    <= '0;
            s1_sat_reg    <= 1'b0;
            cur_reg       <= '0;
            dac_data_reg  <= {1'b1, {(DAC_WIDTH-1){1'b0}}};
            dac_valid_reg <= 1'b0;
            rail_cnt_reg  <= '0;
        end else begin
            s1_valid_reg  <= accept && active;
            s1_sum_reg    <= sum_sat;
            s1_sat_reg    <= sat_hi || sat_lo;
            dac_valid_reg <= s2_fire;
            if (s2_fire) begin
                cur_reg      <= cur_next;
                dac_data_reg <= DAC_WIDTH'(to_offset_binary(32'(cur_next), DAC_WIDTH));
                rail_cnt_reg <= rail_cnt_next;
            end
            if (!en) begin
                state_reg    <= ST_IDLE;
                rail_cnt_reg <= '0;
            end else begin
                case (state_reg)
                    ST_IDLE:  state_reg <= ST_TRACK;
                    ST_TRACK: begin
                        if (hold) begin
                            state_reg <= ST_HOLD;
                        end else if (s2_fire && (rail_cnt_next == CNT_W'(RAIL_COUNT))) begin
                            state_reg <= ST_RAIL;
                        end
                    end
                    ST_RAIL: begin
                        if (hold) begin
                            state_reg <= ST_HOLD;
                        end else if (s2_fire && !s1_sat_reg) begin
                            state_reg <= ST_TRACK;
                        end
                    end
                    ST_HOLD: begin
                        if (!hold) begin
                            state_reg    <= ST_TRACK;
                            rail_cnt_reg <= '0;
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

    assign dac_data  = dac_data_reg;
    assign dac_valid = dac_valid_reg;
    assign rail_flag = (state_reg == ST_RAIL);
    assign state     = state_reg;

endmodule

// File: tb/tb_axis_actuator_driver.sv
// Scoreboard bench for axis_actuator_driver with an integer-arithmetic reference model.
module tb_axis_actuator_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] tdata = '0;
    logic        tvalid = 1'b0;
    logic        tready;
    logic        en = 1'b0;
    logic        hold = 1'b0;
    logic [13:0] offset = '0;
    logic [12:0] max_step = '0;
    logic [13:0] dac_data;
    logic        dac_valid;
    logic        rail_flag;
    logic [1:0]  state;

    int checks = 0;
    int failures = 0;
    int txn = 0;

    typedef struct {
        logic [13:0] dac;
        logic        rail;
    } exp_t;
    exp_t exp_q[$];

    // Reference model state: mode 0..3 = IDLE/TRACK/RAIL/HOLD, values as plain ints.
    int m_mode = 0;
    int m_cur = 0;
    int m_cnt = 0;
    bit m_pv = 0;
    int m_psum = 0;
    bit m_psat = 0;

    axis_actuator_driver dut (
        .clk                (clk),
        .rst                (rst),
        .axis_ACTION_tdata  (tdata),
        .axis_ACTION_tvalid (tvalid),
        .axis_ACTION_tready (tready),
        .en                 (en),
        .hold               (hold),
        .OFFSET             (offset),
        .MAX_STEP           (max_step),
        .dac_data           (dac_data),
        .dac_valid          (dac_valid),
        .rail_flag          (rail_flag),
        .state              (state)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] ob(input int v);
        logic [13:0] w;
        w = 14'(v);
        return w ^ 14'h2000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference model: evaluates one clock edge from the rules of the driver.
    always @(posedge clk) begin
        int  d;
        int  s;
        int  tgt;
        bit  active;
        bit  acc;
        bit  fire;
        logic signed [31:0] sh;
        if (rst) begin
            m_mode = 0; m_cur = 0; m_cnt = 0; m_pv = 0;
        end else begin
            active = (m_mode == 1) || (m_mode == 2);
            acc    = tvalid && (m_mode != 0);
            fire   = m_pv && active;
            if (fire) begin
                d = m_psum - m_cur;
                if (max_step != 0 && (d > int'(max_step) || -d > int'(max_step)))
                    m_cur = m_cur + ((d > 0) ? int'(max_step) : -int'(max_step));
                else
                    m_cur = m_psum;
                m_cnt = m_psat ? ((m_cnt < 4) ? m_cnt + 1 : 4) : 0;
            end
            if (!en) begin
                m_mode = 0; m_cnt = 0;
            end else if (m_mode == 0) begin
                m_mode = 1;
            end else if (m_mode == 3) begin
                if (!hold) begin m_mode = 1; m_cnt = 0; end
            end else if (hold) begin
                m_mode = 3;
            end else if (m_mode == 1 && fire && m_cnt == 4) begin
                m_mode = 2;
            end else if (m_mode == 2 && fire && !m_psat) begin
                m_mode = 1;
            end
            if (fire) exp_q.push_back('{dac: ob(m_cur), rail: (m_mode == 2)});
            sh  = $signed(tdata) >>> 18;
            tgt = int'(sh);
            s   = tgt + int'($signed(offset));
            m_psat = (s > 8191) || (s < -8192);
            m_psum = (s > 8191) ? 8191 : ((s < -8192) ? -8192 : s);
            m_pv   = acc && active;
        end
    end

    // Monitor: per-cycle state/level checks and scoreboard pops on each dac_valid.
    always @(negedge clk) begin
        exp_t e;
        chk("state", 32'(state), 32'(m_mode));
        chk("tready", 32'(tready), 32'(m_mode != 0));
        chk("dac_level", 32'(dac_data), 32'(ob(m_cur)));
        if (dac_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 32'(dac_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                txn++;
                chk("txn_dac", 32'(dac_data), 32'(e.dac));
                chk("txn_rail", 32'(rail_flag), 32'(e.rail));
                $display("txn %0d dac_data=%h rail_flag=%b expected=%h/%b",
                         txn, dac_data, rail_flag, e.dac, e.rail);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Reset state
        cycles(3);
        chk("rst_dac", 32'(dac_data), 32'h2000);
        chk("rst_valid", 32'(dac_valid), 32'd0);
        chk("rst_tready", 32'(tready), 32'd0);
        chk("rst_state", 32'(state), 32'd0);

        // Slewed ramp to target 1000 with MAX_STEP=100
        rst = 1'b0; en = 1'b1; offset = 14'd0; max_step = 13'd100;
        tvalid = 1'b1; tdata = 32'h0FA00000;
        cycles(20);
        chk("ramp_final", 32'(dac_data), 32'h23E8);
        chk("ramp_state", 32'(state), 32'd1);

        // Ramp toward -1000, hold for 5 cycles, then resume
        tdata = 32'hF0600000;
        cycles(4);
        hold = 1'b1;
        cycles(2);
        for (int i = 0; i < 3; i++) begin
            chk("hold_valid", 32'(dac_valid), 32'd0);
            chk("hold_tready", 32'(tready), 32'd1);
            chk("hold_state", 32'(state), 32'd3);
            cycles(1);
        end
        hold = 1'b0;
        cycles(25);
        chk("resume_final", 32'(dac_data), 32'(ob(-1000)));

        // Saturation and rail detection
        max_step = 13'd0; offset = 14'd8000; tdata = 32'h0FA00000;
        cycles(8);
        chk("sat_dac", 32'(dac_data), 32'h3FFF);
        chk("rail_high", 32'(rail_flag), 32'd1);
        tdata = 32'h0;
        cycles(4);
        chk("rail_low", 32'(rail_flag), 32'd0);
        chk("unsat_dac", 32'(dac_data), 32'h3F40);

        // Reset mid-ramp, then restart and measure first-update latency
        offset = 14'd0; max_step = 13'd50; tdata = 32'hF0600000;
        cycles(5);
        rst = 1'b1;
        cycles(1);
        chk("midrst_dac", 32'(dac_data), 32'h2000);
        chk("midrst_state", 32'(state), 32'd0);
        rst = 1'b0;
        cycles(1);
        chk("restart_state", 32'(state), 32'd1);
        chk("restart_v0", 32'(dac_valid), 32'd0);
        cycles(1);
        chk("restart_v1", 32'(dac_valid), 32'd0);
        cycles(1);
        chk("restart_v2", 32'(dac_valid), 32'd1);
        chk("restart_dac", 32'(dac_data), 32'(ob(-50)));

        // en=0 overrides hold
        hold = 1'b1;
        cycles(2);
        en = 1'b0;
        cycles(1);
        chk("en_over_hold_state", 32'(state), 32'd0);
        chk("en_over_hold_tready", 32'(tready), 32'd0);
        hold = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            rst    = ($urandom % 300) == 0;
            en     = ($urandom % 25) != 0;
            hold   = ($urandom % 12) == 0;
            tvalid = ($urandom % 4) != 0;
            tdata  = $urandom;
            if (($urandom % 40) == 0) offset = 14'($urandom);
            if (($urandom % 40) == 0)
                max_step = (($urandom % 3) == 0) ? 13'd0 : 13'($urandom_range(1, 8191));
            cycles(1);
        end

        // Drain and confirm every expected update was observed
        rst = 1'b0; en = 1'b1; hold = 1'b0; tvalid = 1'b0;
        cycles(5);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
